// File: rtl/cdp_dp_chnwin_gen_pkg.sv
// Shared CDP channel-window definitions: geometry, window width and FSM encoding.
package cdp_dp_chnwin_gen_pkg;
  localparam int CDP_TP     = 4;
  localparam int CDP_ICVTO  = 9;
  localparam int CDP_HALO   = 4;
  localparam int CDP_INFO_W = 15;
  localparam int CDP_CHN_W  = 13;
  localparam int CDP_WIN_W  = CDP_ICVTO*(CDP_TP+2*CDP_HALO)+CDP_INFO_W;

  typedef enum logic [1:0] {
    CW_EMPTY = 2'd0,
    CW_HOLD  = 2'd1,
    CW_FLUSH = 2'd2
  } chnwin_st_e;

  function automatic int win_w(input int tp, input int icvto);
    return icvto*(tp+2*CDP_HALO)+CDP_INFO_W;
  endfunction
endpackage

// File: rtl/cdp_dp_chnwin_gen_mask.sv
// Last-group channel mask: lanes beyond the cube depth are zeroed on the final group of a pixel.
module cdp_chnwin_mask #(
  parameter int TP    = 4,
  parameter int ICVTO = 9,
  parameter int LG    = $clog2(TP)
) (
  input  logic [TP*ICVTO-1:0] data,
  input  logic                last,
  input  logic [LG-1:0]       chn_lo,
  output logic [TP*ICVTO-1:0] masked
);
  for (genvar k = 0; k < TP; k++) begin : g_lane
    logic drop;
    assign drop = last && (LG'(k) > chn_lo);
    assign masked[ICVTO*k +: ICVTO] = drop ? '0 : data[ICVTO*k +: ICVTO];
  end
endmodule

// File: rtl/cdp_dp_chnwin_gen.sv
// CDP channel-window generator: wraps each channel group with 4-element halos from its
// neighbours, zero-filling outside the cube, and forwards the group's info.
module cdp_dp_chnwin_gen
  import cdp_dp_chnwin_gen_pkg::*;
#(
  parameter int TP    = CDP_TP,
  parameter int ICVTO = CDP_ICVTO
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rstn,
  input  logic                        cvt2buf_pvld,
  output logic                        cvt2buf_prdy,
  input  logic [TP*ICVTO-1:0]         cvt2buf_data,
  input  logic [CDP_INFO_W-1:0]       cvt2buf_info,
  input  logic                        cvt2buf_last,
  input  logic [CDP_CHN_W-1:0]        reg2dp_datin_channel,
  output logic                        normalz_buf_data_pvld,
  input  logic                        normalz_buf_data_prdy,
  output logic [win_w(TP,ICVTO)-1:0]  normalz_buf_data
);
  localparam int LG = $clog2(TP);
  localparam int GW = TP*ICVTO;
  localparam int HW = CDP_HALO*ICVTO;
  localparam int WW = win_w(TP, ICVTO);

  chnwin_st_e            st, st_nxt;
  logic [GW-1:0]         cur, in_msk;
  logic [HW-1:0]         prev_hi;
  logic [CDP_INFO_W-1:0] cur_info;
  logic                  out_free, accept, load;
  logic [WW-1:0]         load_data;
  logic                  unused_chn;

  assign unused_chn = ^reg2dp_datin_channel[CDP_CHN_W-1:LG];

  cdp_chnwin_mask #(.TP(TP), .ICVTO(ICVTO)) u_mask (
    .data   (cvt2buf_data),
    .last   (cvt2buf_last),
    .chn_lo (reg2dp_datin_channel[LG-1:0]),
    .masked (in_msk)
  );

  assign out_free = ~normalz_buf_data_pvld | normalz_buf_data_prdy;
  assign accept   = cvt2buf_pvld & cvt2buf_prdy;

  always_comb begin
    st_nxt       = st;
    cvt2buf_prdy = 1'b0;
    load         = 1'b0;
    load_data    = {cur_info, {HW{1'b0}}, cur, prev_hi};
    case (st)
      CW_EMPTY: begin
        cvt2buf_prdy = 1'b1;
        if (cvt2buf_pvld) st_nxt = cvt2buf_last ? CW_FLUSH : CW_HOLD;
      end
      CW_HOLD: begin
        cvt2buf_prdy = out_free;
        if (cvt2buf_pvld && out_free) begin
          load      = 1'b1;
          load_data = {cur_info, in_msk[HW-1:0], cur, prev_hi};
          st_nxt    = cvt2buf_last ? CW_FLUSH : CW_HOLD;
        end
      end
      CW_FLUSH: begin
        // hi halo of the last group is past the cube, so it closes with zeros
        if (out_free) begin
          load   = 1'b1;
          st_nxt = CW_EMPTY;
        end
      end
      default: st_nxt = CW_EMPTY;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) st <= CW_EMPTY;
    else                  st <= st_nxt;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cur      <= '0;
      cur_info <= '0;
      prev_hi  <= '0;
    end else if (accept) begin
      cur      <= in_msk;
      cur_info <= cvt2buf_info;
      prev_hi  <= (st == CW_EMPTY) ? '0 : cur[GW-1 -: HW];
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      normalz_buf_data_pvld <= 1'b0;
      normalz_buf_data      <= '0;
    end else if (load) begin
      normalz_buf_data_pvld <= 1'b1;
      normalz_buf_data      <= load_data;
    end else if (normalz_buf_data_prdy) begin
      normalz_buf_data_pvld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdp_dp_chnwin_gen.sv
// Scoreboard bench for cdp_dp_chnwin_gen: directed pixels push expected windows, a monitor pops on handshake.
module tb_cdp_dp_chnwin_gen;
  localparam int TP = 4;
  localparam int EW = 9;
  localparam int GW = TP*EW;
  localparam int WW = EW*(TP+8)+15;

  logic          nvdla_core_clk, nvdla_core_rstn;
  logic          cvt2buf_pvld, cvt2buf_prdy, cvt2buf_last;
  logic [GW-1:0] cvt2buf_data;
  logic [14:0]   cvt2buf_info;
  logic [12:0]   reg2dp_datin_channel;
  logic          normalz_buf_data_pvld, normalz_buf_data_prdy;
  logic [WW-1:0] normalz_buf_data;

  cdp_dp_chnwin_gen #(.TP(TP), .ICVTO(EW)) dut (
    .nvdla_core_clk        (nvdla_core_clk),
    .nvdla_core_rstn       (nvdla_core_rstn),
    .cvt2buf_pvld          (cvt2buf_pvld),
    .cvt2buf_prdy          (cvt2buf_prdy),
    .cvt2buf_data          (cvt2buf_data),
    .cvt2buf_info          (cvt2buf_info),
    .cvt2buf_last          (cvt2buf_last),
    .reg2dp_datin_channel  (reg2dp_datin_channel),
    .normalz_buf_data_pvld (normalz_buf_data_pvld),
    .normalz_buf_data_prdy (normalz_buf_data_prdy),
    .normalz_buf_data      (normalz_buf_data)
  );

  initial begin
    nvdla_core_clk = 1'b0;
    forever #5 nvdla_core_clk = ~nvdla_core_clk;
  end

  logic [WW-1:0] exp_q[$];
  int n_cmp = 0, n_err = 0, n_push = 0, n_rx = 0;
  int acc_cnt = 0, stall_cnt = 0;

  function automatic logic [WW-1:0] mkwin(input int e[12], input logic [14:0] inf);
    logic [WW-1:0] w;
    w = '0;
    for (int j = 0; j < 12; j++) w[EW*j +: EW] = 9'(e[j]);
    w[WW-1 -: 15] = inf;
    return w;
  endfunction

  function automatic logic [GW-1:0] grp(input int a, input int b, input int c, input int d);
    return {9'(d), 9'(c), 9'(b), 9'(a)};
  endfunction

  task automatic push(input int e[12], input logic [14:0] inf);
    exp_q.push_back(mkwin(e, inf));
    n_push++;
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; acceptance is judged at the falling edge.
  task automatic send(input logic [GW-1:0] d, input logic [14:0] inf, input logic lst);
    int n;
    n = 0;
    cvt2buf_pvld = 1'b1;
    cvt2buf_data = d;
    cvt2buf_info = inf;
    cvt2buf_last = lst;
    forever begin
      @(negedge nvdla_core_clk);
      if (cvt2buf_prdy) break;
      n++;
      if (n > 200) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout: input never accepted within %0d cycles", n);
        break;
      end
    end
    @(posedge nvdla_core_clk); #1;
    cvt2buf_pvld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge nvdla_core_clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d windows still pending, expected 0", exp_q.size());
    end
    repeat (2) @(posedge nvdla_core_clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on each output handshake and checks stability while held.
  initial begin
    logic          held;
    logic [WW-1:0] held_d, e;
    held = 1'b0;
    held_d = '0;
    forever begin
      @(negedge nvdla_core_clk);
      if (!nvdla_core_rstn) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        n_cmp++;
        if (!(normalz_buf_data_pvld === 1'b1 && normalz_buf_data === held_d)) begin
          n_err++;
          $display("FAIL hold_stable: got pvld=%0b data=%h, expected pvld=1 data=%h",
                   normalz_buf_data_pvld, normalz_buf_data, held_d);
        end
      end
      if (normalz_buf_data_pvld && normalz_buf_data_prdy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_window: got %h, expected no window", normalz_buf_data);
        end else begin
          e = exp_q.pop_front();
          n_rx++;
          if (normalz_buf_data !== e) begin
            n_err++;
            $display("FAIL window_%0d: got %h, expected %h", n_rx-1, normalz_buf_data, e);
          end
        end
      end
      held   = normalz_buf_data_pvld && !normalz_buf_data_prdy;
      held_d = normalz_buf_data;
      if (cvt2buf_pvld && cvt2buf_prdy) acc_cnt++;
      if (!cvt2buf_prdy) stall_cnt++;
    end
  end

  initial begin
    int e[12];
    int s0, a0, b;
    nvdla_core_rstn       = 1'b0;
    cvt2buf_pvld          = 1'b0;
    cvt2buf_data          = '0;
    cvt2buf_info          = '0;
    cvt2buf_last          = 1'b0;
    reg2dp_datin_channel  = '0;
    normalz_buf_data_prdy = 1'b1;
    #2;
    check("reset_pvld", int'(normalz_buf_data_pvld), 0);
    check("reset_data_zero", int'(normalz_buf_data == '0), 1);
    check("reset_in_prdy", int'(cvt2buf_prdy), 1);
    @(posedge nvdla_core_clk); #1;
    nvdla_core_rstn = 1'b1;
    @(posedge nvdla_core_clk); #1;

    // single-group pixel
    reg2dp_datin_channel = 13'd3;
    e = '{0,0,0,0,1,2,3,4,0,0,0,0}; push(e, 15'h1234);
    s0 = stall_cnt;
    send(grp(1,2,3,4), 15'h1234, 1'b1);
    drain();
    check("single_stall_cycles", stall_cnt - s0, 1);

    // two-group pixel
    reg2dp_datin_channel = 13'd7;
    e = '{0,0,0,0,1,2,3,4,5,6,7,8}; push(e, 15'h1);
    e = '{1,2,3,4,5,6,7,8,0,0,0,0}; push(e, 15'h2);
    send(grp(1,2,3,4), 15'h1, 1'b0);
    send(grp(5,6,7,8), 15'h2, 1'b1);
    drain();

    // last-group masking, C=6
    reg2dp_datin_channel = 13'd5;
    e = '{0,0,0,0,1,2,3,4,5,6,0,0}; push(e, 15'h3);
    e = '{1,2,3,4,5,6,0,0,0,0,0,0}; push(e, 15'h4);
    send(grp(1,2,3,4), 15'h3, 1'b0);
    send(grp(5,6,9'h1FF,9'h1FF), 15'h4, 1'b1);
    drain();

    // backpressure mid-pixel, C=16
    reg2dp_datin_channel = 13'd15;
    e = '{0,0,0,0,1,2,3,4,5,6,7,8};         push(e, 15'h10);
    e = '{1,2,3,4,5,6,7,8,9,10,11,12};      push(e, 15'h11);
    e = '{5,6,7,8,9,10,11,12,13,14,15,16};  push(e, 15'h12);
    e = '{9,10,11,12,13,14,15,16,0,0,0,0};  push(e, 15'h13);
    fork
      begin
        send(grp(1,2,3,4),     15'h10, 1'b0);
        send(grp(5,6,7,8),     15'h11, 1'b0);
        send(grp(9,10,11,12),  15'h12, 1'b0);
        send(grp(13,14,15,16), 15'h13, 1'b1);
      end
      begin
        repeat (2) @(posedge nvdla_core_clk);
        #1;
        normalz_buf_data_prdy = 1'b0;
        a0 = acc_cnt;
        repeat (10) @(posedge nvdla_core_clk);
        #1;
        check("bp_in_prdy_low", int'(cvt2buf_prdy), 0);
        check("bp_absorbed_le1", int'((acc_cnt - a0) <= 1), 1);
        normalz_buf_data_prdy = 1'b1;
      end
    join
    drain();

    // three back-to-back C=8 pixels
    reg2dp_datin_channel = 13'd7;
    for (int p = 0; p < 3; p++) begin
      b = 10*p + 1;
      for (int j = 0; j < 12; j++) e[j] = (j < 4) ? 0 : b + j - 4;
      push(e, 15'(16*p));
      for (int j = 0; j < 12; j++) e[j] = (j < 8) ? b + j : 0;
      push(e, 15'(16*p + 1));
    end
    s0 = stall_cnt;
    for (int p = 0; p < 3; p++) begin
      b = 10*p + 1;
      send(grp(b, b+1, b+2, b+3), 15'(16*p), 1'b0);
      send(grp(b+4, b+5, b+6, b+7), 15'(16*p + 1), 1'b1);
    end
    drain();
    check("b2b_stall_cycles", stall_cnt - s0, 3);

    // reset mid-pixel: window held by backpressure is discarded
    reg2dp_datin_channel = 13'd11;
    normalz_buf_data_prdy = 1'b0;
    send(grp(1,2,3,4), 15'h5, 1'b0);
    send(grp(5,6,7,8), 15'h6, 1'b0);
    check("pre_reset_pvld", int'(normalz_buf_data_pvld), 1);
    #2;
    nvdla_core_rstn = 1'b0;
    #1;
    check("async_reset_pvld", int'(normalz_buf_data_pvld), 0);
    check("async_reset_data_zero", int'(normalz_buf_data == '0), 1);
    check("async_reset_in_prdy", int'(cvt2buf_prdy), 1);
    @(posedge nvdla_core_clk); #1;
    nvdla_core_rstn = 1'b1;
    normalz_buf_data_prdy = 1'b1;
    reg2dp_datin_channel = 13'd3;
    e = '{0,0,0,0,1,2,3,4,0,0,0,0}; push(e, 15'h1234);
    send(grp(1,2,3,4), 15'h1234, 1'b1);
    drain();

    check("windows_delivered", n_rx, n_push);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
